counter_bank: RTL and testbench
===============================

# counter_bank

Multi-channel cycle/event counter bank: CHANNELS independent COUNTER_SIZE-bit counters with per-channel enable and clear, selectable wrap or saturate mode, a shared compare threshold with per-channel match pulses, sticky overflow flags, and an atomic snapshot of all channels into shadow registers. It is the generalised successor of the single free-running cycle counter. It sits beside the measurement datapath, where one snapshot strobe freezes a coherent set of counts that software or a readout FSM then reads one channel at a time through a select port.

## Interface

Parameters:
- COUNTER_SIZE, 40, width of every counter and shadow register (≥2)
- CHANNELS, 4, number of counter channels (≥1)
- SEL_WIDTH, 2, width of the channel select; must satisfy 2^SEL_WIDTH ≥ CHANNELS

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clock_i  in  1  rising-edge clock for all state
- reset_i  in  1  synchronous, active-high reset
- enable_i  in  CHANNELS  bit k = count enable for channel k
- clear_i  in  CHANNELS  bit k = synchronous clear of counter k and overflow k
- saturate_i  in  1  0 = wrap at max, 1 = hold at max (global, sampled every cycle)
- compareValue_i  in  COUNTER_SIZE  shared match threshold
- snapshot_i  in  1  capture all live counters into shadow registers
- select_i  in  SEL_WIDTH  channel index for both read ports
- counterOut_o  out  COUNTER_SIZE  live count of selected channel
- snapshotOut_o  out  COUNTER_SIZE  shadow value of selected channel
- snapshotValid_o  out  1  one-cycle pulse after a capture
- match_o  out  CHANNELS  per-channel registered match pulse
- overflow_o  out  CHANNELS  per-channel sticky overflow flag

## Operation

- Reset (reset_i=1 at an edge): all counters, shadows, match_o, overflow_o and snapshotValid_o go to 0. Reset overrides every other input.
- Per channel k, priority at each edge: clear_i[k] > enable_i[k] > hold.
  - clear: count ← 0, overflow_o[k] ← 0, match_o[k] ← 0.
  - enable, count < MAX (2^COUNTER_SIZE−1): count ← count+1.
  - enable, count = MAX, saturate_i=0: count ← 0, overflow_o[k] ← 1.
  - enable, count = MAX, saturate_i=1: count stays MAX, overflow_o[k] ← 1.
- Overflow is sticky. Only clear_i[k] or reset clears it. Clear wins over a simultaneous overflow event.
- match_o[k] ← 1 for exactly the edge on which an enabled increment or wrap makes the new count equal compareValue_i. Otherwise it is 0.
  - Clear never produces a match, even when compareValue_i=0.
  - A saturated hold at MAX never re-asserts the match.
  - A wrap to 0 with compareValue_i=0 does assert the match.
- Snapshot: on an edge with snapshot_i=1, every shadow[k] ← the pre-edge count of channel k, i.e. the value visible on counterOut_o in the strobe cycle. A same-cycle clear or increment does not affect the captured value. All channels are captured on the same edge. Shadows hold until the next snapshot or reset.
- snapshotValid_o ← snapshot_i, so it is registered and high for one cycle after each strobe. Back-to-back strobes keep it high.
- Read ports are combinational muxes of registers, indexed by select_i. If select_i ≥ CHANNELS, both outputs read 0.

## Timing

- Count, overflow, match and shadow update on the rising edge; there are no combinational paths from enable_i, clear_i or snapshot_i to outputs.
- Latency:
  - enable_i → counterOut_o change: 1 cycle.
  - snapshot_i → snapshotOut_o and snapshotValid_o: 1 cycle.
  - select_i → read ports: 0 cycles (combinational).
- match_o[k] and the new count appear on the same cycle. overflow_o[k] rises on the same edge as the wrap or saturate event.
- Reset mid-operation: the next cycle shows all outputs at 0, regardless of pending strobes.
- Full-rate operation: enable may be held high indefinitely. One increment per cycle per channel.

## Test plan

Bench configuration: COUNTER_SIZE=4, CHANNELS=4, SEL_WIDTH=2.
- Reset, then enable_i=4'b0001 for 5 cycles, select_i=0 → counterOut_o=5. With select_i=1 → counterOut_o=0.
- Wrap: saturate_i=0, channel 2 enabled for 17 cycles → count 15→0 on cycle 16, overflow_o[2]=1 from then on, final count 1. Then clear_i[2] for one cycle → count 0, overflow_o[2]=0.
- Saturate: saturate_i=1, channel 3 enabled for 20 cycles → count holds 15, overflow_o[3]=1. compareValue_i=15 → match_o[3] pulses once only, on the cycle the count first shows 15.
- Snapshot coherence: channels 0/1 at 7/3 with both enabled, snapshot_i and clear_i[1] asserted in the same cycle → shadows 7/3, live values 8/0, snapshotValid_o high for exactly 1 cycle.
- Priority: clear_i[0] and enable_i[0] both high at count 9 → count 0. compareValue_i=0 → no match pulse.
- Out-of-range select: CHANNELS=3, select_i=3 → counterOut_o=0 and snapshotOut_o=0. Reset asserted mid-count → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/counter_bank.sv
// Bank of independent event counters with wrap/saturate, shared compare threshold,
// sticky overflow flags and a coherent snapshot of all channels into shadow registers.
module counter_bank #(
  parameter int COUNTER_SIZE = 40,
  parameter int CHANNELS     = 4,
  parameter int SEL_WIDTH    = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [CHANNELS-1:0]     enable_i,
  input  logic [CHANNELS-1:0]     clear_i,
  input  logic                    saturate_i,
  input  logic [COUNTER_SIZE-1:0] compareValue_i,
  input  logic                    snapshot_i,
  input  logic [SEL_WIDTH-1:0]    select_i,
  output logic [COUNTER_SIZE-1:0] counterOut_o,
  output logic [COUNTER_SIZE-1:0] snapshotOut_o,
  output logic                    snapshotValid_o,
  output logic [CHANNELS-1:0]     match_o,
  output logic [CHANNELS-1:0]     overflow_o
);

  localparam logic [COUNTER_SIZE-1:0] MAX_COUNT = '1;

  logic [COUNTER_SIZE-1:0] count_all  [CHANNELS];
  logic [COUNTER_SIZE-1:0] shadow_all [CHANNELS];
  logic                    snapshot_valid_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [COUNTER_SIZE-1:0] count_reg, count_next;
      logic [COUNTER_SIZE-1:0] shadow_reg;
      logic                    match_reg, match_next;
      logic                    overflow_reg, overflow_next;
      logic [COUNTER_SIZE-1:0] count_inc;
      logic                    at_max;

      assign at_max    = (count_reg == MAX_COUNT);
      assign count_inc = count_reg + 1'b1;

      always_comb begin
        count_next    = count_reg;
        overflow_next = overflow_reg;
        match_next    = 1'b0;
        if (clear_i[gi]) begin
          count_next    = '0;
          overflow_next = 1'b0;
        end else if (enable_i[gi]) begin
          if (at_max) overflow_next = 1'b1;
          // A saturated hold never re-asserts the match; a wrap to zero may.
          if (!(at_max && saturate_i)) begin
            count_next = count_inc;
            match_next = (count_inc == compareValue_i);
          end
        end
      end

      always_ff @(posedge clock_i) begin
        if (reset_i) begin
          count_reg    <= '0;
          match_reg    <= 1'b0;
          overflow_reg <= 1'b0;
          shadow_reg   <= '0;
        end else begin
          count_reg    <= count_next;
          match_reg    <= match_next;
          overflow_reg <= overflow_next;
          // Shadow takes the pre-edge count, unaffected by same-cycle clear/increment.
          if (snapshot_i) shadow_reg <= count_reg;
        end
      end

      assign count_all[gi]  = count_reg;
      assign shadow_all[gi] = shadow_reg;
      assign match_o[gi]    = match_reg;
      assign overflow_o[gi] = overflow_reg;
    end
  endgenerate

  always_ff @(posedge clock_i) begin
    if (reset_i) snapshot_valid_reg <= 1'b0;
    else         snapshot_valid_reg <= snapshot_i;
  end

  assign snapshotValid_o = snapshot_valid_reg;

  // Unused select codes fall through to zero.
  always_comb begin
    counterOut_o  = '0;
    snapshotOut_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (select_i == SEL_WIDTH'(i)) begin
        counterOut_o  = count_all[i];
        snapshotOut_o = shadow_all[i];
      end
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Scoreboard bench for counter_bank: driver pushes model expectations, monitor pops
// and compares each cycle; a 3-channel instance covers the unused select code.
module tb_counter_bank;

  localparam int CS  = 4;
  localparam int CH  = 4;
  localparam int MAX = (1 << CS) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0, clr = '0;
  logic          sat = 1'b0, snap = 1'b0;
  logic [CS-1:0] cmp = '0;
  logic [1:0]    sel = '0;

  logic [CS-1:0] cnt_out, shd_out, cnt_out3, shd_out3;
  logic          sv_out, sv_out3;
  logic [CH-1:0] match_out, ovf_out;
  logic [2:0]    match_out3, ovf_out3;

  always #5 clk = ~clk;

  counter_bank #(.COUNTER_SIZE(CS), .CHANNELS(CH), .SEL_WIDTH(2)) dut (
    .clock_i(clk), .reset_i(rst), .enable_i(en), .clear_i(clr), .saturate_i(sat),
    .compareValue_i(cmp), .snapshot_i(snap), .select_i(sel),
    .counterOut_o(cnt_out), .snapshotOut_o(shd_out), .snapshotValid_o(sv_out),
    .match_o(match_out), .overflow_o(ovf_out));

  counter_bank #(.COUNTER_SIZE(CS), .CHANNELS(3), .SEL_WIDTH(2)) dut3 (
    .clock_i(clk), .reset_i(rst), .enable_i(en[2:0]), .clear_i(clr[2:0]), .saturate_i(sat),
    .compareValue_i(cmp), .snapshot_i(snap), .select_i(sel),
    .counterOut_o(cnt_out3), .snapshotOut_o(shd_out3), .snapshotValid_o(sv_out3),
    .match_o(match_out3), .overflow_o(ovf_out3));

  typedef struct {
    int         id;
    logic [1:0] sel;
    int         cnt;
    int         shd;
    logic       sv;
    logic [3:0] mt;
    logic [3:0] ov;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   txn_id = 0;

  // Reference model state: counts as plain integers.
  int m_cnt [CH];
  int m_shd [CH];
  bit m_ovf [CH];
  bit m_mt  [CH];
  bit m_sv;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic logic [3:0] pack_bits(input bit b [CH]);
    logic [3:0] v;
    for (int k = 0; k < CH; k++) v[k] = b[k];
    return v;
  endfunction

  task automatic step(input logic [3:0] e, input logic [3:0] c, input logic s,
                      input logic [3:0] cv, input logic sn, input logic [1:0] sl,
                      input logic r);
    exp_t x;
    @(negedge clk);
    en = e; clr = c; sat = s; cmp = cv; snap = sn; sel = sl; rst = r;
    if (r) begin
      for (int k = 0; k < CH; k++) begin
        m_cnt[k] = 0; m_shd[k] = 0; m_ovf[k] = 0; m_mt[k] = 0;
      end
      m_sv = 0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        int nxt;
        if (sn) m_shd[k] = m_cnt[k];
        m_mt[k] = 0;
        if (c[k]) begin
          m_cnt[k] = 0; m_ovf[k] = 0;
        end else if (e[k]) begin
          nxt = m_cnt[k] + 1;
          if (nxt > MAX) begin
            m_ovf[k] = 1;
            if (s) nxt = MAX;
            else begin
              nxt = 0;
              m_mt[k] = (int'(cv) == 0);
            end
          end else begin
            m_mt[k] = (nxt == int'(cv));
          end
          m_cnt[k] = nxt;
        end
      end
      m_sv = sn;
    end
    x.id = txn_id++; x.sel = sl; x.cnt = m_cnt[sl]; x.shd = m_shd[sl]; x.sv = m_sv;
    x.mt = pack_bits(m_mt); x.ov = pack_bits(m_ovf);
    exp_q.push_back(x);
  endtask

  task automatic sweep(input logic s, input logic [3:0] cv);
    for (int i = 0; i < 4; i++) step(4'b0000, 4'b0000, s, cv, 1'b0, 2'(i), 1'b0);
  endtask

  // Monitor: the DUT presents a full set of outputs every cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        $display("txn %0d sel=%0d cnt=%0d/%0d shd=%0d/%0d sv=%0b match=%b ovf=%b",
                 x.id, x.sel, cnt_out, x.cnt, shd_out, x.shd, sv_out, match_out, ovf_out);
        chk("count",       int'(cnt_out),   x.cnt);
        chk("shadow",      int'(shd_out),   x.shd);
        chk("snap_valid",  int'(sv_out),    int'(x.sv));
        chk("match",       int'(match_out), int'(x.mt));
        chk("overflow",    int'(ovf_out),   int'(x.ov));
        chk("ch3_overflow", int'(ovf_out3), int'(x.ov[2:0]));
        chk("ch3_match",    int'(match_out3), int'(x.mt[2:0]));
        if (x.sel == 2'd3) begin
          chk("ch3_oor_count",  int'(cnt_out3), 0);
          chk("ch3_oor_shadow", int'(shd_out3), 0);
        end else begin
          chk("ch3_count",  int'(cnt_out3), x.cnt);
          chk("ch3_shadow", int'(shd_out3), x.shd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    step(4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 4'd0, 1'b1, 2'd0, 1'b1);
    // Channel 0 counts 5
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0000, 1'b0, 4'd9, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd9, 1'b0, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd9, 1'b0, 2'd0, 1'b0);
    // Wrap on channel 2, then clear it
    step(4'b0000, 4'b1111, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0);
    for (int i = 0; i < 17; i++) step(4'b0100, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0);
    step(4'b0000, 4'b0100, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd2, 1'b0);
    // Saturate on channel 3 with compare at max
    for (int i = 0; i < 20; i++) step(4'b1000, 4'b0000, 1'b1, 4'd15, 1'b0, 2'd3, 1'b0);
    sweep(1'b1, 4'd15);
    // Snapshot coherence: ch0=7, ch1=3, then snapshot with clear on ch1
    step(4'b0000, 4'b1111, 1'b0, 4'd12, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(4'b0011, 4'b0000, 1'b0, 4'd12, 1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) step(4'b0001, 4'b0000, 1'b0, 4'd12, 1'b0, 2'd0, 1'b0);
    step(4'b0011, 4'b0010, 1'b0, 4'd12, 1'b1, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd12, 1'b0, 2'd1, 1'b0);
    sweep(1'b0, 4'd12);
    // Back-to-back snapshots
    step(4'b1111, 4'b0000, 1'b0, 4'd12, 1'b1, 2'd0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 4'd12, 1'b1, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd12, 1'b0, 2'd1, 1'b0);
    // Priority: clear beats enable at count 9, compare=0 gives no match
    step(4'b0000, 4'b0001, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 9; i++) step(4'b0001, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd3, 1'b0);
    // Reset mid-count with a pending snapshot
    for (int i = 0; i < 4; i++) step(4'b1111, 4'b0000, 1'b0, 4'd0, 1'b1, 2'd1, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 4'd0, 1'b1, 2'd1, 1'b1);
    sweep(1'b0, 4'd0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0] e, c, cv;
      logic s, sn, r;
      logic [1:0] sl;
      e  = 4'($urandom);
      c  = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
      s  = ($urandom_range(0, 2) == 0);
      cv = 4'($urandom);
      sn = ($urandom_range(0, 5) == 0);
      sl = 2'($urandom);
      r  = ($urandom_range(0, 99) == 0);
      step(e, c, s, cv, sn, sl, r);
    end
    step(4'b0000, 4'b0000, 1'b0, 4'd0, 1'b0, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
